// File: rtl/vmask_set_first.sv
`default_nettype none
// ============================================================================
//  Module   : vmask_set_first
//  Purpose  : Two-stage pipelined vmsbf / vmsif / vmsof over a stream of mask
//             packs, carrying a per-instruction "set bit already seen" flag.
//  Revision : 1.0  initial release
// ============================================================================
module vmask_set_first #(
    parameter int REQ_DATA_WIDTH  = 64,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int REQ_ADDR_WIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_DATA_WIDTH-1:0]  in_m0,
    input  logic                       in_valid,
    input  logic                       in_end,
    input  logic [REQ_ADDR_WIDTH-1:0]  in_addr,
    input  logic [1:0]                 in_opSel,
    output logic [RESP_DATA_WIDTH-1:0] out_vec,
    output logic [REQ_ADDR_WIDTH-1:0]  out_addr,
    output logic                       out_valid,
    output logic                       out_end
);

    localparam logic [1:0] c_OP_SBF = 2'b00;
    localparam logic [1:0] c_OP_SIF = 2'b01;
    localparam logic [1:0] c_OP_SOF = 2'b10;
    localparam logic [1:0] c_OP_RSV = 2'b11;
    localparam logic [REQ_DATA_WIDTH-1:0] c_ONE = {{(REQ_DATA_WIDTH-1){1'b0}}, 1'b1};

    if (RESP_DATA_WIDTH != REQ_DATA_WIDTH) begin : g_width_check
        $error("vmask_set_first: RESP_DATA_WIDTH must equal REQ_DATA_WIDTH");
    end

    // Stage 0: captured inputs (data forced to zero on idle cycles)
    logic                       r_s0_valid;
    logic [REQ_DATA_WIDTH-1:0]  r_s0_mask;
    logic                       r_s0_end;
    logic [REQ_ADDR_WIDTH-1:0]  r_s0_addr;
    logic [1:0]                 r_s0_op;

    logic                       r_found;
    logic                       r_out_valid;
    logic [RESP_DATA_WIDTH-1:0] r_out_vec;
    logic [REQ_ADDR_WIDTH-1:0]  r_out_addr;
    logic                       r_out_end;

    logic [REQ_DATA_WIDTH-1:0]  w_low;
    logic [REQ_DATA_WIDTH-1:0]  w_below;
    logic [RESP_DATA_WIDTH-1:0] w_result;
    logic                       w_found_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_mask  <= '0;
            r_s0_end   <= 1'b0;
            r_s0_addr  <= '0;
            r_s0_op    <= '0;
        end else begin
            r_s0_valid <= in_valid;
            r_s0_mask  <= in_valid ? in_m0    : '0;
            r_s0_end   <= in_valid ? in_end   : 1'b0;
            r_s0_addr  <= in_valid ? in_addr  : '0;
            r_s0_op    <= in_valid ? in_opSel : '0;
        end
    end

    // Lowest set bit isolated; a zero pack gives w_low=0 and w_below=all ones
    assign w_low   = r_s0_mask & (~r_s0_mask + c_ONE);
    assign w_below = w_low - c_ONE;

    always_comb begin
        w_result = '0;
        if (!r_found) begin
            case (r_s0_op)
                c_OP_SBF: w_result = w_below;
                c_OP_SIF: w_result = w_below | w_low;
                c_OP_SOF: w_result = w_low;
                default:  w_result = '0;
            endcase
        end
    end

    // End of instruction clears found and wins over setting it
    always_comb begin
        w_found_nxt = r_found;
        if (r_s0_valid) begin
            if (r_s0_end) begin
                w_found_nxt = 1'b0;
            end else if ((r_s0_op != c_OP_RSV) && (|r_s0_mask)) begin
                w_found_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_found     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_vec   <= '0;
            r_out_addr  <= '0;
            r_out_end   <= 1'b0;
        end else begin
            r_found     <= w_found_nxt;
            r_out_valid <= r_s0_valid;
            r_out_vec   <= r_s0_valid ? w_result  : '0;
            r_out_addr  <= r_s0_valid ? r_s0_addr : '0;
            r_out_end   <= r_s0_valid ? r_s0_end  : 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_vec   = r_out_vec;
    assign out_addr  = r_out_addr;
    assign out_end   = r_out_end;

endmodule
`default_nettype wire

// File: tb/tb_vmask_set_first.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vmask_set_first
//  Purpose  : Directed self-checking bench for vmask_set_first with a
//             per-cycle reference model and literal spot checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vmask_set_first;

    localparam int DW = 64;
    localparam int AW = 32;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] vec;
        logic [AW-1:0] addr;
        logic          e;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_m0;
    logic          in_valid;
    logic          in_end;
    logic [AW-1:0] in_addr;
    logic [1:0]    in_opSel;
    logic [DW-1:0] out_vec;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_end;

    vmask_set_first #(
        .REQ_DATA_WIDTH (DW),
        .RESP_DATA_WIDTH(DW),
        .REQ_ADDR_WIDTH (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_m0    (in_m0),
        .in_valid (in_valid),
        .in_end   (in_end),
        .in_addr  (in_addr),
        .in_opSel (in_opSel),
        .out_vec  (out_vec),
        .out_addr (out_addr),
        .out_valid(out_valid),
        .out_end  (out_end)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    int    n_pass = 0;
    int    n_total = 0;
    logic  m_found = 1'b0;
    beat_t exp_q[int];
    beat_t got_q[int];

    always @(posedge clk) cyc = cyc + 1;

    // Reference: scan for lowest set bit p, then build the mask bit by bit
    function automatic logic [DW-1:0] model_vec(input logic [1:0] op, input logic [DW-1:0] m,
                                                input logic fnd);
        int p;
        logic [DW-1:0] r;
        p = -1;
        r = '0;
        for (int i = DW - 1; i >= 0; i--) if (m[i]) p = i;
        if (fnd || op == 2'b11) return r;
        if (p < 0) return (op == 2'b10) ? r : ~r;
        for (int i = 0; i < DW; i++) begin
            if (op == 2'b00 && i < p)  r[i] = 1'b1;
            if (op == 2'b01 && i <= p) r[i] = 1'b1;
            if (op == 2'b10 && i == p) r[i] = 1'b1;
        end
        return r;
    endfunction

    task automatic send(input logic v, input logic [DW-1:0] m, input logic e,
                        input logic [AW-1:0] a, input logic [1:0] op, output int dc);
        beat_t x;
        @(posedge clk);
        #1;
        in_valid = v;
        in_m0    = m;
        in_end   = e;
        in_addr  = a;
        in_opSel = op;
        dc       = cyc;
        if (v) begin
            x.v    = 1'b1;
            x.vec  = model_vec(op, m, m_found);
            x.addr = a;
            x.e    = e;
            exp_q[cyc + 2] = x;
            if (e) m_found = 1'b0;
            else if (op != 2'b11 && m != '0) m_found = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        int dc;
        for (int i = 0; i < n; i++)
            send(1'b0, {$urandom, $urandom}, 1'b1, $urandom, 2'($urandom_range(3)), dc);
    endtask

    function automatic beat_t got_at(input int c);
        beat_t z;
        z = '0;
        if (got_q.exists(c)) z = got_q[c];
        return z;
    endfunction

    task automatic lit(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, got, want);
    endtask

    always @(negedge clk) begin
        beat_t x;
        beat_t g;
        x = '0;
        if (exp_q.exists(cyc)) x = exp_q[cyc];
        g = {out_valid, out_vec, out_addr, out_end};
        got_q[cyc] = g;
        n_total++;
        if (g === x) n_pass++;
        else $display("FAIL cycle %0d: got v=%b vec=%h addr=%h end=%b, want v=%b vec=%h addr=%h end=%b",
                      cyc, g.v, g.vec, g.addr, g.e, x.v, x.vec, x.addr, x.e);
    end

    int d1, d2, d3, d4, d5, d6, d7, dx;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_m0 = '0; in_end = 1'b0; in_addr = '0; in_opSel = '0;
        repeat (3) @(posedge clk);
        #1;
        lit("reset_valid", 64'(out_valid), 64'd0);
        lit("reset_vec",   out_vec,        64'd0);
        lit("reset_addr",  64'(out_addr),  64'd0);
        lit("reset_end",   64'(out_end),   64'd0);
        #2 rst = 1'b0;
        idle(2);

        // vmsbf single pack with end
        send(1'b1, 64'h10, 1'b1, 32'h100, 2'b00, d1);
        idle(1);
        // vmsif three packs back-to-back
        send(1'b1, 64'h0,                1'b0, 32'h200, 2'b01, d2);
        send(1'b1, 64'h8000000000000000, 1'b0, 32'h201, 2'b01, dx);
        send(1'b1, 64'h1,                1'b1, 32'h202, 2'b01, dx);
        // vmsof across an instruction boundary
        send(1'b1, 64'h6, 1'b1, 32'h300, 2'b10, d3);
        send(1'b1, 64'h6, 1'b1, 32'h301, 2'b10, dx);
        idle(2);
        // vmsof zero pack
        send(1'b1, 64'h0, 1'b1, 32'h400, 2'b10, d4);
        // reserved op between two vmsbf packs must not set found
        send(1'b1, 64'h0,                1'b0, 32'h600, 2'b00, d6);
        send(1'b1, 64'h5555555555555555, 1'b0, 32'h601, 2'b11, dx);
        send(1'b1, 64'h4,                1'b1, 32'h602, 2'b00, dx);
        idle(3);

        // async reset with one pack visible, one in stage 0, one at the inputs
        send(1'b1, 64'h80, 1'b0, 32'h500, 2'b00, d5);
        send(1'b1, 64'h1,  1'b0, 32'h501, 2'b00, dx);
        send(1'b1, 64'h2,  1'b1, 32'h502, 2'b00, dx);
        #2;
        lit("t5_pre_valid", 64'(out_valid), 64'd1);
        lit("t5_pre_vec",   out_vec,        64'h7F);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        m_found = 1'b0;
        for (int k = cyc; k <= cyc + 2; k++) if (exp_q.exists(k)) exp_q.delete(k);
        #1;
        lit("t5_rst_valid", 64'(out_valid), 64'd0);
        lit("t5_rst_vec",   out_vec,        64'd0);
        lit("t5_rst_addr",  64'(out_addr),  64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        send(1'b1, 64'h4, 1'b1, 32'h510, 2'b00, d7);
        idle(4);

        lit("t1_valid", 64'(got_at(d1 + 2).v), 64'd1);
        lit("t1_vec",   got_at(d1 + 2).vec,    64'h000000000000000F);
        lit("t1_end",   64'(got_at(d1 + 2).e), 64'd1);
        lit("t2_vec0",  got_at(d2 + 2).vec,    64'hFFFFFFFFFFFFFFFF);
        lit("t2_vec1",  got_at(d2 + 3).vec,    64'hFFFFFFFFFFFFFFFF);
        lit("t2_vec2",  got_at(d2 + 4).vec,    64'h0);
        lit("t3_vec0",  got_at(d3 + 2).vec,    64'h2);
        lit("t3_vec1",  got_at(d3 + 3).vec,    64'h2);
        lit("t4_valid", 64'(got_at(d4 + 2).v), 64'd1);
        lit("t4_vec",   got_at(d4 + 2).vec,    64'h0);
        lit("t4_addr",  64'(got_at(d4 + 2).addr), 64'h400);
        lit("t6_vec0",  got_at(d6 + 2).vec,    64'hFFFFFFFFFFFFFFFF);
        lit("t6_vec1",  got_at(d6 + 3).vec,    64'h0);
        lit("t6_valid1", 64'(got_at(d6 + 3).v), 64'd1);
        lit("t6_vec2",  got_at(d6 + 4).vec,    64'h3);
        lit("t5_a_gone", 64'(got_at(d5 + 3).v), 64'd0);
        lit("t5_b_gone", 64'(got_at(d5 + 4).v), 64'd0);
        lit("t5_post_vec", got_at(d7 + 2).vec, 64'h3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
